// File: rtl/d_latch_pkg.sv
// Shared constants for the d_latch bank: reset levels, synchroniser depth and
// the default statistics counter width.
package d_latch_pkg;

   localparam logic Q_RST       = 1'b0;
   localparam logic QB_RST      = 1'b1;
   localparam int   SYNC_STAGES = 2;
   localparam int   STAT_W_DEF  = 16;

endpackage

// File: rtl/d_latch_cell.sv
// One bit of the gated D latch: two input NAND gates steer a cross-coupled
// NAND storage pair, with a clear that overrides everything.
module d_latch_cell
   import d_latch_pkg::*;
(
   input  logic i_d,
   input  logic i_en,
   input  logic i_clr,
   output logic o_q,
   output logic o_qb
);

   logic w_setN;
   logic w_rstN;
   logic r_q;

   assign w_setN = ~(i_d & i_en);
   assign w_rstN = ~(w_setN & i_en);

   // Cross-coupled pair: a low set/reset NAND output drives the stored bit,
   // both high means hold.
   always_latch begin
      if (i_clr)
         r_q <= Q_RST;
      else if (!w_setN)
         r_q <= 1'b1;
      else if (!w_rstN)
         r_q <= 1'b0;
   end

   assign o_q  = r_q;
   assign o_qb = i_clr ? QB_RST : ~r_q;

endmodule

// File: rtl/d_latch.sv
// Bank of WIDTH gated D latches with a synchronised reset release.
// Optional enable-cycle statistics counter when DLATCH_STATS_EN is defined.
module d_latch
   import d_latch_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int STAT_W = STAT_W_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  D,
   input  logic              en,
   output logic [WIDTH-1:0]  Q,
   output logic [WIDTH-1:0]  Qb
`ifdef DLATCH_STATS_EN
   ,
   output logic [STAT_W-1:0] en_cnt
`endif
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_clr;

   // Assertion clears the latches at once; release only after SYNC_STAGES edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sync <= '0;
      else
         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
   end

   assign w_clr = ~r_sync[SYNC_STAGES-1];

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      d_latch_cell u_cell (
         .i_d   (D[gi]),
         .i_en  (en),
         .i_clr (w_clr),
         .o_q   (Q[gi]),
         .o_qb  (Qb[gi])
      );
   end

`ifdef DLATCH_STATS_EN
   logic [STAT_W-1:0] r_enCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_enCnt <= '0;
      else if (en && (r_enCnt != '1))
         r_enCnt <= r_enCnt + STAT_W'(1);
   end

   assign en_cnt = r_enCnt;
`endif

endmodule

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch (WIDTH=8) against a behavioural latch model.
module tb_d_latch;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] D;
   logic         en;
   logic [W-1:0] Q;
   logic [W-1:0] Qb;
`ifdef DLATCH_STATS_EN
   logic [15:0]  en_cnt;
`endif

   int checks;
   int fails;

   // Model: latch opens after two clock edges with reset released; value held while closed.
   int           mRelEdges;
   logic [W-1:0] mHeld;
   logic [W-1:0] expVal;

   d_latch #(.WIDTH(W), .STAT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .D     (D),
      .en    (en),
      .Q     (Q),
      .Qb    (Qb)
`ifdef DLATCH_STATS_EN
      ,
      .en_cnt(en_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mRelEdges <= 0;
      else if (mRelEdges < 2)
         mRelEdges <= mRelEdges + 1;
   end

   task automatic modelUpdate();
      if (!rst_n || mRelEdges < 2)
         mHeld = '0;
      else if (en)
         mHeld = D;
      expVal = mHeld;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      D     = '0;
      repeat (2) @(negedge clk);
      #1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {expVal, ~expVal}) begin
         fails++;
         $display("[TB] FAIL reset_held: Q=%h Qb=%h expected Q=%h Qb=%h", Q, Qb, expVal, ~expVal);
      end
      @(negedge clk);
      rst_n = 1'b1;
      D     = '0;
      #1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'h00, 8'hFF}) begin
         fails++;
         $display("[TB] FAIL reset_en0_d0: Q=%h Qb=%h expected Q=00 Qb=FF", Q, Qb);
      end
      @(negedge clk);
      D = '1;
      #1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'h00, 8'hFF}) begin
         fails++;
         $display("[TB] FAIL reset_en0_d1: Q=%h Qb=%h expected Q=00 Qb=FF", Q, Qb);
      end
      repeat (3) @(negedge clk);
      #1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'h00, 8'hFF}) begin
         fails++;
         $display("[TB] FAIL reset_never_opened: Q=%h Qb=%h expected Q=00 Qb=FF", Q, Qb);
      end
   endtask

   task automatic test_transparent();
      @(negedge clk);
      en = 1'b1;
      D  = 8'h00;
      #1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'h00, 8'hFF}) begin
         fails++;
         $display("[TB] FAIL transparent_d0: Q=%h Qb=%h expected Q=00 Qb=FF", Q, Qb);
      end
      #1;
      D = 8'hFF;
      #0.1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'hFF, 8'h00}) begin
         fails++;
         $display("[TB] FAIL transparent_d1: Q=%h Qb=%h expected Q=FF Qb=00", Q, Qb);
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] pattern [3];
      pattern[0] = 8'h00;
      pattern[1] = 8'hFF;
      pattern[2] = 8'h00;
      @(negedge clk);
      en = 1'b1;
      D  = 8'hFF;
      #1;
      modelUpdate();
      @(negedge clk);
      en = 1'b0;
      #1;
      modelUpdate();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         D = pattern[i];
         #1;
         modelUpdate();
         checks++;
         if ({Q, Qb} !== {8'hFF, 8'h00}) begin
            fails++;
            $display("[TB] FAIL hold_toggle%0d: Q=%h Qb=%h expected Q=FF Qb=00", i, Q, Qb);
         end
      end
   endtask

   task automatic test_reset_transparent();
      @(negedge clk);
      en = 1'b1;
      D  = 8'hFF;
      #1;
      modelUpdate();
      #2;
      rst_n = 1'b0;
      #0.5;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'h00, 8'hFF}) begin
         fails++;
         $display("[TB] FAIL rst_immediate: Q=%h Qb=%h expected Q=00 Qb=FF", Q, Qb);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      modelUpdate();
      checks++;
      if (Q !== 8'h00) begin
         fails++;
         $display("[TB] FAIL rst_release_edge0: Q=%h expected 00", Q);
      end
      @(posedge clk);
      #1;
      modelUpdate();
      checks++;
      if (Q !== 8'h00) begin
         fails++;
         $display("[TB] FAIL rst_release_edge1: Q=%h expected 00", Q);
      end
      @(posedge clk);
      #1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'hFF, 8'h00}) begin
         fails++;
         $display("[TB] FAIL rst_release_edge2: Q=%h Qb=%h expected Q=FF Qb=00", Q, Qb);
      end
   endtask

   task automatic test_width();
      @(negedge clk);
      en = 1'b1;
      D  = 8'hA5;
      #1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'hA5, 8'h5A}) begin
         fails++;
         $display("[TB] FAIL width_a5: Q=%h Qb=%h expected Q=A5 Qb=5A", Q, Qb);
      end
      @(negedge clk);
      en = 1'b0;
      #1;
      modelUpdate();
      D = 8'h00;
      #1;
      modelUpdate();
      checks++;
      if ({Q, Qb} !== {8'hA5, 8'h5A}) begin
         fails++;
         $display("[TB] FAIL width_hold: Q=%h Qb=%h expected Q=A5 Qb=5A", Q, Qb);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0)
            en = ~en;
         else
            D = W'($urandom);
         #1;
         modelUpdate();
         checks++;
         if ({Q, Qb} !== {expVal, ~expVal} || (en && Q !== D)) begin
            fails++;
            $display("[TB] FAIL random%0d: en=%b D=%h Q=%h Qb=%h expected Q=%h Qb=%h",
                     i, en, D, Q, Qb, expVal, ~expVal);
         end
      end
   endtask

`ifdef DLATCH_STATS_EN
   task automatic test_stats();
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b1;
      #1;
      modelUpdate();
      checks++;
      if (en_cnt !== 16'd0) begin
         fails++;
         $display("[TB] FAIL stats_reset: en_cnt=%0d expected 0", en_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (en_cnt !== 16'd5) begin
         fails++;
         $display("[TB] FAIL stats_count5: en_cnt=%0d expected 5", en_cnt);
      end
      @(negedge clk);
      en    = 1'b0;
      rst_n = 1'b0;
      #1;
      modelUpdate();
      checks++;
      if (en_cnt !== 16'd0) begin
         fails++;
         $display("[TB] FAIL stats_clear: en_cnt=%0d expected 0", en_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      checks = 0;
      fails  = 0;
      mHeld  = '0;
      expVal = '0;
      rst_n  = 1'b0;
      en     = 1'b0;
      D      = '0;
      test_reset();
      test_transparent();
      test_hold();
      test_reset_transparent();
      test_width();
      test_random();
`ifdef DLATCH_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/d_latch.md
# d_latch

Gated, level-sensitive D latch bank with complementary outputs, built per bit from a four-NAND gated-latch cell. While `en` is high the outputs follow `D` transparently. While `en` is low they hold the last value. It is used as a storage or hold element wherever a transparent-while-enabled register is needed, and a single clock is used only for reset-release synchronisation and optional statistics.

## Interface
- `WIDTH`, default 1: number of latch bits.
- `STAT_W`, default 16: width of the statistics counter (only used with the macro).
- `clk`  input  1: clock. Used for reset synchronisation and statistics only; never gates the data path.
- `rst_n`  input  1: reset. One clock; reset is asynchronous and active-low.
- `D`  input  WIDTH: data input.
- `en`  input  1: latch enable. 1 = transparent, 0 = hold.
- `Q`  output  WIDTH: latched data.
- `Qb`  output  WIDTH: complement of `Q`.
- `en_cnt`  output  STAT_W: count of clock cycles with `en` sampled high. Present only when `DLATCH_STATS_EN` is defined.

## Operation
- Reset asserted (`rst_n`=0): immediately forces `Q`=0 and `Qb`=all ones, regardless of `en` and `D`.
- Reset released, `en`=1: `Q`=`D` and `Qb`=~`D` combinationally, bit for bit. No clock edge is involved.
- Reset released, `en`=0: `Q` and `Qb` hold the value present when `en` fell, or the reset value if `en` has not been high since reset.
- `D` changes while `en`=0 have no effect on the outputs.
- `Qb` equals ~`Q` at all times once the outputs have settled, including during reset.
- The internal latch clear is driven by the synchronised reset, so a transparent or held value is never disturbed by a partial reset release.

## Timing
- Data path from `D` or `en` to `Q`/`Qb` is purely combinational (zero cycles). The only delay is gate propagation.
- Reset assertion is asynchronous: outputs reach 0/1 with no clock.
- Reset deassertion goes through a 2-flop synchroniser on `clk`. The latch leaves the reset state on the 2nd rising `clk` edge after `rst_n` rises. Until then, `en`=1 does not open the latch.
- If `en` and `D` change together while `en` falls, the latch captures the `D` value that was stable before the `en` falling edge. `D` must be stable for one gate delay around `en` falling.
- Reset during transparency: outputs go to 0/1 at once. After release, the latch follows `D` again if `en` is still high.

## Configuration
- `DLATCH_STATS_EN` defined:
  - Adds port `en_cnt`.
  - The counter increments on each rising `clk` edge where `en`=1, and saturates at all ones.
  - It is cleared asynchronously by `rst_n`.
- `DLATCH_STATS_EN` undefined: no port, no counter. The data-path behaviour is identical in both cases.

## Structure
- Package `d_latch_pkg` holds:
  - Reset constants: `Q_RST`=0, `QB_RST`=1.
  - `SYNC_STAGES`=2.
  - The default `STAT_W`.
- Sub-module `d_latch_cell`: one bit built from four NAND gates plus a clear input, instantiated WIDTH times with a generate loop.
- The top level holds the reset synchroniser and the optional statistics counter.

## Test plan
- Reset, then `en`=0 with `D`=0 and then `D`=1 (10 ns each) -> `Q`=0, `Qb`=1 throughout.
- `en`=1, `D`=0 -> `Q`=0, `Qb`=1. Then `D`=1 -> `Q`=1, `Qb`=0 within the same time step, with no clock edge needed.
- `en`=1, `D`=1, then `en`=0, then `D` toggles 0/1/0 -> `Q` stays 1 and `Qb` stays 0.
- `en`=1, `D`=1, then pulse `rst_n` low mid-cycle -> `Q`=0 at once. `Q` returns to 1 exactly 2 `clk` edges after `rst_n` rises.
- `WIDTH`=8, `en`=1, `D`=8'hA5 -> `Q`=8'hA5, `Qb`=8'h5A. Then `en`=0 and `D`=8'h00 -> `Q` stays 8'hA5.
- With `DLATCH_STATS_EN` defined: hold `en`=1 for 5 `clk` edges -> `en_cnt`=5. Assert reset -> `en_cnt`=0.
